decade_chain_ctrl: RTL
======================

// Module: decade_chain_ctrl
// PURPOSE
//  Run controller for a chain of NUM_DIGITS cascaded 0-9 (BCD) digit counters.
//  - Owns the digit registers and a tick prescaler.
//  - Generates the per-digit carry enables.
//  - Sequences run/pause/clear via an FSM.
//  - Stops on a programmable terminal BCD value.
//  Sits between the command/control logic and any display or compare logic that consumes bcd.
// PARAMETERS
//  NUM_DIGITS  2  number of cascaded decade digits (1..8)
//  PRESCALE    4  clk cycles per count tick (>=1); 1 = tick every RUN cycle
// PORTS
//  clk       in   1             clock, rising edge
//  rst       in   1             synchronous reset, active-high
//  start     in   1             pulse: start / resume / restart
//  stop      in   1             pulse: pause counting
//  clear     in   1             pulse: abort to IDLE, zero digits
//  term_bcd  in   4*NUM_DIGITS  terminal value, digit 0 in [3:0]; sampled on accepted start
//  bcd       out  4*NUM_DIGITS  current count, digit i in [4i+3:4i]
//  dig_en    out  NUM_DIGITS    per-digit advance enables this cycle (combinational from registers)
//  state     out  2             0 = IDLE, 1 = RUN, 2 = PAUSE, 3 = DONE
//  done      out  1             1-cycle pulse on entry to DONE
//  ovf       out  1             1-cycle pulse when the chain wraps all-9 -> all-0
// BEHAVIOUR
//  Reset: rst=1 at a rising edge gives state=IDLE, bcd=0, prescaler=0, done=0, ovf=0, term reg=0.
//   - Applies from any state, including mid-RUN.
//  Command priority: clear > stop > start. Lower-priority commands in the same cycle are ignored.
//  FSM transitions:
//   - IDLE:  start -> RUN; count continues from bcd (0 after reset/clear); latch term_bcd.
//   - RUN:   stop -> PAUSE. Terminal match -> DONE.
//   - PAUSE: start -> RUN; term reg NOT relatched; prescaler resumes from its held value.
//   - DONE:  start -> RUN with bcd=0, prescaler=0, and term_bcd relatched.
//   - Any state: clear -> IDLE with bcd=0, prescaler=0.
//  Prescaler: counts 0..PRESCALE-1 only while in RUN with no stop/clear that cycle.
//   - tick=1 when it equals PRESCALE-1; it then wraps to 0.
//   - Holds in PAUSE. Zeroed in IDLE, in DONE, and by clear.
//   - A stop in the tick cycle suppresses the tick: no digit update.
//  Carry chain:
//   - dig_en[0] = tick.
//   - dig_en[i] = dig_en[i-1] & (digit[i-1]==9).
//   - An enabled digit goes d -> d+1, with 9 -> 0.
//   - dig_en = 0 outside RUN.
//  ovf: asserted the cycle after a tick that moves all digits 9 -> 0. Counting continues.
//  Terminal:
//   - Compared only against the updated value produced by a tick.
//   - If next bcd == term reg: the next state is DONE, and done=1 for exactly the first DONE cycle.
//   - bcd holds in DONE.
//   - A term that equals bcd at start time matches only after the value recurs (full wrap).
//   - A term nibble > 9 never matches, so the chain free-runs.
//  Out-of-range digits cannot arise: all digit writes are 0..9.
// CONFIGURATION
//  DECADE_CTRL_DOWN_EN defined: adds input port dir (1 bit, sampled every tick).
//   - dir=1: dig_en[i] = dig_en[i-1] & (digit[i-1]==0); an enabled digit goes d -> d-1, with 0 -> 9.
//   - dir=1: ovf pulses on the all-0 -> all-9 wrap.
//   - dir=0: up-count behaviour exactly as above.
//  DECADE_CTRL_DOWN_EN undefined: dir port absent; up-count only.
// TESTING (NUM_DIGITS=2, PRESCALE=4)
//  1. rst, then start with term_bcd=8'h15 -> bcd increments every 4 clk; bcd=8'h15 60 clk after start;
//     state=3; done high exactly 1 clk.
//  2. bcd=8'h09, tick -> dig_en=2'b11 that cycle; bcd=8'h10 next.
//  3. term_bcd=8'hFF, run to 8'h99, tick -> bcd=8'h00; ovf 1 clk; state stays RUN.
//  4. stop with bcd=8'h03 and prescaler=2 -> PAUSE; bcd holds for 20 clk.
//     start -> bcd=8'h04 exactly 2 clk after resume.
//  5. In RUN, clear+stop+start in one cycle -> IDLE, bcd=0.
//     rst mid-RUN -> IDLE, bcd=0 at the next edge.
//     start in DONE -> RUN from 8'h00.
//  6. (DECADE_CTRL_DOWN_EN) dir=1, bcd=8'h00, tick -> bcd=8'h99 and ovf=1.
//     bcd=8'h10, tick -> 8'h09.

Source files
------------

// File: rtl/decade_chain_ctrl.sv
// Run controller for a cascade of BCD decade digits: prescaled tick, carry chain,
// run/pause/clear FSM and terminal-value stop. Define DECADE_CTRL_DOWN_EN to add a dir input for down-counting.
module decade_chain_ctrl #(
    parameter int NUM_DIGITS = 2,
    parameter int PRESCALE   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    clear,
`ifdef DECADE_CTRL_DOWN_EN
    input  logic                    dir,
`endif
    input  logic [4*NUM_DIGITS-1:0] term_bcd,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic [1:0]              state,
    output logic                    done,
    output logic                    ovf
);

    localparam int              PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]              r_state;
    logic [4*NUM_DIGITS-1:0] r_bcd;
    logic [4*NUM_DIGITS-1:0] r_term;
    logic [PRE_W-1:0]        r_pre;
    logic                    r_done;
    logic                    r_ovf;

    logic                    w_down;
    logic                    w_tick;
    logic [NUM_DIGITS-1:0]   w_dig_en;
    logic [4*NUM_DIGITS-1:0] w_bcd_nxt;
    logic                    w_wrap_all;

`ifdef DECADE_CTRL_DOWN_EN
    assign w_down = dir;
`else
    assign w_down = 1'b0;
`endif

    // A stop or clear in the tick cycle swallows the tick entirely.
    assign w_tick = (r_state == S_RUN) && !stop && !clear && (r_pre == PRE_LAST);

    always_comb begin : carry_chain
        logic       carry;
        logic [3:0] digit;
        // NOTE: every output of this block gets a default first so no latch is inferred.
        carry      = w_tick;
        digit      = 4'd0;
        w_dig_en   = '0;
        w_bcd_nxt  = r_bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit       = r_bcd[4*i +: 4];
            w_dig_en[i] = carry;
            if (carry) begin
                if (w_down)
                    w_bcd_nxt[4*i +: 4] = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
                else
                    w_bcd_nxt[4*i +: 4] = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
            end
            carry = carry & (digit == (w_down ? 4'd0 : 4'd9));
        end
        w_wrap_all = carry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_bcd   <= '0;
            r_term  <= '0;
            r_pre   <= '0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
            if (clear) begin
                r_state <= S_IDLE;
                r_bcd   <= '0;
                r_pre   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!stop && start) begin
                            r_state <= S_RUN;
                            r_term  <= term_bcd;
                        end
                    end
                    S_RUN: begin
                        if (stop) begin
                            r_state <= S_PAUSE;
                        end else begin
                            r_bcd <= w_bcd_nxt;
                            r_ovf <= w_wrap_all;
                            if (w_tick) begin
                                r_pre <= '0;
                                if (w_bcd_nxt == r_term) begin
                                    r_state <= S_DONE;
                                    r_done  <= 1'b1;
                                end
                            end else begin
                                r_pre <= r_pre + 1'b1;
                            end
                        end
                    end
                    S_PAUSE: begin
                        if (!stop && start)
                            r_state <= S_RUN;
                    end
                    S_DONE: begin
                        // Restart from zero with a freshly sampled terminal value.
                        if (!stop && start) begin
                            r_state <= S_RUN;
                            r_bcd   <= '0;
                            r_pre   <= '0;
                            r_term  <= term_bcd;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bcd    = r_bcd;
    assign dig_en = w_dig_en;
    assign state  = r_state;
    assign done   = r_done;
    assign ovf    = r_ovf;

endmodule
